// File: rtl/stream_bit_transpose.sv
// Serial-to-parallel bit-matrix transposer: buffers NUM rows of IW bits, then emits IW columns of NUM bits.
// Define STREAM_TRANSPOSE_BITREV_EN to place row 0 in the output MSB instead of the LSB.
module stream_bit_transpose #(
    parameter int NUM = 8,
    parameter int IW  = 6
) (
    input  logic            clock,
    input  logic            rst,
    input  logic [IW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [NUM-1:0]  out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready
);

    localparam int WW = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int RW = (IW > 1) ? $clog2(IW) : 1;
    localparam logic [WW-1:0] WR_LAST = WW'(NUM - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(IW - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    logic [WW-1:0]   wr_cnt;
    logic [RW-1:0]   rd_cnt;
    logic [IW-1:0]   mem [NUM];
    logic            in_fire;
    logic            out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            for (int r = 0; r < NUM; r++) begin
                mem[r] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        mem[wr_cnt] <= in_data;
                        if (wr_cnt == WR_LAST || in_last) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (rd_cnt == RD_LAST) begin
                            // Clearing here keeps unwritten rows of a short next frame at zero.
                            state     <= FILL;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            rd_cnt    <= '0;
                            for (int r = 0; r < NUM; r++) begin
                                mem[r] <= '0;
                            end
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (state == DRAIN) begin
            for (int r = 0; r < NUM; r++) begin
`ifdef STREAM_TRANSPOSE_BITREV_EN
                out_data[r] = mem[NUM-1-r][rd_cnt];
`else
                out_data[r] = mem[r][rd_cnt];
`endif
            end
            out_last = (rd_cnt == RD_LAST);
        end
    end

endmodule
